// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and buffered load results onto the single register-file write port, and tracks pending writes so decode can stall.
// Latency: an ALU result reaches wen one edge after sampling; a load takes two edges through the FIFO (one edge with WB_ARB_BYPASS_EN when the FIFO is empty and no ALU write competes).
// Backpressure: the ALU path has none and always wins; loads are held off by o_mem_ready once the FIFO is full. Optional feature macro: WB_ARB_BYPASS_EN.
module wb_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  // single-cycle ALU results
  input  logic                       i_alu_valid,
  input  logic [4:0]                 i_alu_rd,
  input  logic [31:0]                i_alu_data,
  // load / long-latency results, valid-ready
  input  logic                       i_mem_valid,
  input  logic [4:0]                 i_mem_rd,
  input  logic [31:0]                i_mem_data,
  output logic                       o_mem_ready,
  // scoreboard allocation from issue
  input  logic                       i_alloc_valid,
  input  logic [4:0]                 i_alloc_rd,
  // decode source lookups
  input  logic [4:0]                 i_rs1,
  input  logic [4:0]                 i_rs2,
  output logic                       o_rs1_busy,
  output logic                       o_rs2_busy,
  // register-file write port
  output logic                       o_wen,
  output logic [4:0]                 o_wreg,
  output logic [31:0]                o_wdata,
  output logic [$clog2(DEPTH+1)-1:0] o_fifo_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  // FIFO state
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [4:0]    r_fifo_rd   [DEPTH];
  logic [31:0]   r_fifo_data [DEPTH];

  // write-port registers
  logic          r_wen;
  logic [4:0]    r_wreg;
  logic [31:0]   r_wdata;

  // pending-write scoreboard; x0 is never tracked
  logic [31:1]   r_pending;

  logic          w_full;
  logic          w_empty;
  logic          w_mem_acc;
  logic          w_alu_win;
  logic          w_pop;
  logic          w_push;
  logic          w_bypass;
  logic          w_nx_wen;
  logic [4:0]    w_nx_wreg;
  logic [31:0]   w_nx_wdata;
  logic [31:1]   w_pend_nx;
  logic [31:0]   w_pend_full;

  assign w_full      = (r_count == CW'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign o_mem_ready = ~w_full & reset_n;

  // A load handshake completes on valid&ready; writes to x0 are swallowed here.
  assign w_mem_acc = i_mem_valid & o_mem_ready & (i_mem_rd != 5'd0);

  // ALU writes to x0 do not use the port, which frees the slot for a pop.
  assign w_alu_win = i_alu_valid & (i_alu_rd != 5'd0);
  assign w_pop     = ~w_alu_win & ~w_empty;

`ifdef WB_ARB_BYPASS_EN
  // Empty FIFO and idle port: the load skips the buffer and writes next cycle.
  assign w_bypass = w_mem_acc & w_empty & ~w_alu_win;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push = w_mem_acc & ~w_bypass;

  // Fixed-priority selection of the next write: ALU, then FIFO head, then bypassed load.
  always_comb begin
    w_nx_wen   = 1'b0;
    w_nx_wreg  = r_wreg;
    w_nx_wdata = r_wdata;
    if (w_alu_win) begin
      w_nx_wen   = 1'b1;
      w_nx_wreg  = i_alu_rd;
      w_nx_wdata = i_alu_data;
    end else if (w_pop) begin
      w_nx_wen   = 1'b1;
      w_nx_wreg  = r_fifo_rd[r_head];
      w_nx_wdata = r_fifo_data[r_head];
    end else if (w_bypass) begin
      w_nx_wen   = 1'b1;
      w_nx_wreg  = i_mem_rd;
      w_nx_wdata = i_mem_data;
    end
  end

  // Register the write port; reg/data hold their last value while wen is low.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wen   <= 1'b0;
      r_wreg  <= 5'd0;
      r_wdata <= 32'd0;
    end else begin
      r_wen <= w_nx_wen;
      if (w_nx_wen) begin
        r_wreg  <= w_nx_wreg;
        r_wdata <= w_nx_wdata;
      end
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves the count alone.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage; contents are meaningless until pushed, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_tail]   <= i_mem_rd;
      r_fifo_data[r_tail] <= i_mem_data;
    end
  end

  // Next scoreboard: clear the register being written, then let a new allocation re-set it.
  always_comb begin
    w_pend_nx = r_pending;
    for (int i = 1; i < 32; i++) begin
      if (w_nx_wen && (w_nx_wreg == 5'(i))) begin
        w_pend_nx[i] = 1'b0;
      end
      if (i_alloc_valid && (i_alloc_rd == 5'(i))) begin
        w_pend_nx[i] = 1'b1;
      end
    end
  end

  // Scoreboard register; reset drops every pending bit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pend_nx;
    end
  end

  // Bit 0 is hard-wired low so x0 never reports busy.
  assign w_pend_full = {r_pending, 1'b0};
  assign o_rs1_busy  = w_pend_full[i_rs1];
  assign o_rs2_busy  = w_pend_full[i_rs2];

  assign o_wen        = r_wen;
  assign o_wreg       = r_wreg;
  assign o_wdata      = r_wdata;
  assign o_fifo_count = r_count;

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter that drives the register file's single write port (`wreg`/`wdata`/`wen`). It merges single-cycle ALU results with buffered load/long-latency results and guarantees at most one write per cycle. It also keeps a pending-write scoreboard so decode can stall on `rs1`/`rs2` whose value is still in flight.

## Interface
- `DEPTH`, default 4: entries in the load-result FIFO; power of two, ≥2.
- `clk` in 1: clock.
- `reset_n` in 1: reset, synchronous, active-low.
- `alu_valid` in 1: ALU result present this cycle; no backpressure.
- `alu_rd` in 5: ALU destination register.
- `alu_data` in 32: ALU result.
- `mem_valid` in 1: load result offered.
- `mem_rd` in 5: load destination register.
- `mem_data` in 32: load result.
- `mem_ready` out 1: FIFO can accept; transfer occurs when `mem_valid & mem_ready`.
- `alloc_valid` in 1: long-latency op issued; marks `alloc_rd` pending.
- `alloc_rd` in 5: destination register being allocated.
- `rs1`, `rs2` in 5 each: decode source registers.
- `rs1_busy`, `rs2_busy` out 1 each: source has a pending write.
- `wen` out 1: register-file write enable; registered.
- `wreg` out 5: write register; registered.
- `wdata` out 32: write data; registered.
- `fifo_count` out $clog2(DEPTH+1): FIFO occupancy.

## Operation
- FIFO:
  - Circular buffer with head and tail pointers and a count.
  - Push on `mem_valid & mem_ready`.
  - `mem_ready = ~full & reset_n`.
  - Pushes with `mem_rd==0` are accepted and discarded: no entry, count unchanged.
- Arbitration at each edge, fixed priority:
  1. If `alu_valid` and `alu_rd!=0`, load the ALU result into the output register.
  2. Otherwise, if the FIFO is non-empty, pop the head into the output register.
  3. Otherwise `wen<=0`.
- An ALU write to x0 occupies no slot, so the FIFO may pop in that cycle.
- `wreg`/`wdata` hold their last value while `wen=0`.
- Simultaneous push and pop: count unchanged, both pointers advance. A push into a full FIFO that is also popping is illegal, because `mem_ready=0` when full.
- Scoreboard `pending[31:1]`:
  - Set on `alloc_valid` with `alloc_rd!=0`.
  - Cleared on the edge that loads `wen<=1` with `wreg` equal to that register.
  - Same register set and cleared on the same edge: set wins, because a new op owns the register.
- `rsN_busy = pending[rsN]`, combinational. Always 0 for x0.
- Consistency with the register file:
  - In the cycle `wen` is high, busy is already 0.
  - The register file's write-through supplies the data.
- ALU results are not tracked by the scoreboard. Decode handles them by forwarding.

## Timing
- Reset values:
  - `wen=0`, `wreg=0`, `wdata=0`, `fifo_count=0`.
  - `pending` all 0, `mem_ready=0` while `reset_n` is low.
  - Pointers 0.
- Reset mid-operation discards FIFO contents and pending bits. No write is issued for dropped entries.
- ALU latency: `alu_valid` sampled at edge N gives `wen=1` in cycle N→N+1. The register file commits at edge N+1.
- Load latency without bypass:
  - Pushed at edge N.
  - Earliest pop at edge N+1, so `wen` is high in cycle N+1→N+2.
- Back-to-back ALU results starve the FIFO indefinitely. Loads stall via `mem_ready` once the FIFO is full.
- `fifo_count` reflects post-edge state.

## Configuration
- `WB_ARB_BYPASS_EN` defined:
  - A load accepted at edge N while the FIFO is empty and there is no valid non-x0 ALU result goes straight to the output register.
  - Result: `wen=1` in cycle N→N+1, and the FIFO is untouched.
  - The scoreboard clears at edge N.
- `WB_ARB_BYPASS_EN` not defined: every load passes through the FIFO, with the 2-edge latency above.

## Test plan
- Reset and idle checks:
  - Assert `reset_n=0` for 2 cycles with `mem_valid=1` → `wen=0`, `mem_ready=0`, `fifo_count=0`, `rs1_busy=0` for all `rs1`.
  - Then release reset → `mem_ready=1`.
- ALU path:
  - ALU write x5=0xDEADBEEF at edge N → `wen=1`, `wreg=5`, `wdata=0xDEADBEEF` after N.
  - ALU to x0 → `wen` stays 0.
- Priority:
  - Push loads x7=0x11, x8=0x22 while `alu_valid` is held with x3 for 4 cycles → x3 writes only and `fifo_count=2`.
  - Drop `alu_valid` → x7 then x8 are written on consecutive cycles in FIFO order.
- Full FIFO:
  - DEPTH=4; hold `alu_valid` and push 5 loads → `mem_ready=0` after the 4th push and `fifo_count=4`. The 5th load is accepted only after the first pop.
- Scoreboard:
  - `alloc` x9 → `rs2=9` gives busy=1.
  - Load x9=0x55 → busy=0 in the cycle `wen=1`, `wreg=9`.
  - `alloc` x9 on the same edge as that write → busy remains 1.
- Bypass:
  - Empty FIFO, no ALU, single load x4=0x99 at edge N.
  - With `WB_ARB_BYPASS_EN` defined → `wen` is high after N.
  - Without it → `wen` is high after N+1.
